// File: rtl/sram_rd_pkg.sv
// Shared types and SRAM geometry for the weight-image read path.
package sram_rd_pkg;

  localparam int SRAM_ADDR_W = 20;
  localparam int SRAM_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    RD_HI,
    RD_LO,
    PRESENT,
    FIN
  } rd_state_t;

endpackage

// File: rtl/sram_read_phase.sv
// One half-word SRAM read access: registered pin drive, WAIT_CYCLES hold, sample strobe.
module sram_read_phase
  import sram_rd_pkg::*;
#(
  parameter int ADDR_W      = SRAM_ADDR_W,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              launch,
  input  logic [ADDR_W-1:0] launch_addr,
  output logic              sample_en,
  output logic              CE_N,
  output logic              OE_N,
  output logic              LB_N,
  output logic              UB_N,
  output logic [ADDR_W-1:0] sram_address
);

  localparam int PH_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  logic [PH_W-1:0] ph;
  logic            active;

  // ph counts down to zero; the zero cycle is the last one of the access window.
  always_ff @(posedge clk) begin
    if (!reset) begin
      active       <= 1'b0;
      ph           <= '0;
      CE_N         <= 1'b1;
      OE_N         <= 1'b1;
      LB_N         <= 1'b1;
      UB_N         <= 1'b1;
      sram_address <= '0;
    end else if (launch) begin
      active       <= 1'b1;
      ph           <= PH_W'(WAIT_CYCLES);
      CE_N         <= 1'b0;
      OE_N         <= 1'b0;
      LB_N         <= 1'b0;
      UB_N         <= 1'b0;
      sram_address <= launch_addr;
    end else if (active) begin
      if (ph == '0) begin
        active <= 1'b0;
        CE_N   <= 1'b1;
        OE_N   <= 1'b1;
        LB_N   <= 1'b1;
        UB_N   <= 1'b1;
      end else begin
        ph <= ph - 1'b1;
      end
    end
  end

  assign sample_en = active && (ph == '0);

endmodule

// File: rtl/sram_weight_reader.sv
// Reads 32-bit weight words stored as hi/lo 16-bit halves in SRAM and streams them out.
//   state   | meaning
//   IDLE    | waiting for start
//   RD_HI   | reading high half at addr_r
//   RD_LO   | reading low half at addr_r
//   PRESENT | word_valid held until word_ready
//   FIN     | one-cycle done pulse
module sram_weight_reader
  import sram_rd_pkg::*;
#(
  parameter int ADDR_W      = SRAM_ADDR_W,
  parameter int CNT_W       = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [CNT_W-1:0]       word_count,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            word_data,
  output logic                   word_valid,
  input  logic                   word_ready,
  output logic                   CE_N,
  output logic                   OE_N,
  output logic                   WE_N,
  output logic                   LB_N,
  output logic                   UB_N,
  output logic [ADDR_W-1:0]      sram_address,
  inout  wire  [SRAM_DATA_W-1:0] sram_data
);

  rd_state_t              state, state_nxt;
  logic [ADDR_W-1:0]      addr_r;
  logic [CNT_W-1:0]       remaining;
  logic [SRAM_DATA_W-1:0] hi_r;
  logic                   launch;
  logic [ADDR_W-1:0]      launch_addr;
  logic                   sample_en;

  // The block is read-only: sram_data is never driven from here.
  assign WE_N = 1'b1;

  sram_read_phase #(
    .ADDR_W      (ADDR_W),
    .WAIT_CYCLES (WAIT_CYCLES)
  ) u_phase (
    .clk          (clk),
    .reset        (reset),
    .launch       (launch),
    .launch_addr  (launch_addr),
    .sample_en    (sample_en),
    .CE_N         (CE_N),
    .OE_N         (OE_N),
    .LB_N         (LB_N),
    .UB_N         (UB_N),
    .sram_address (sram_address)
  );

  always_comb begin
    state_nxt   = state;
    launch      = 1'b0;
    launch_addr = addr_r;
    case (state)
      IDLE:
        if (start) begin
          if (word_count == '0) begin
            state_nxt = FIN;
          end else begin
            state_nxt   = RD_HI;
            launch      = 1'b1;
            launch_addr = base_addr;
          end
        end
      RD_HI:
        if (sample_en) begin
          state_nxt   = RD_LO;
          launch      = 1'b1;
          launch_addr = addr_r + 1'b1;
        end
      RD_LO:
        if (sample_en) state_nxt = PRESENT;
      PRESENT:
        if (word_valid && word_ready) begin
          if (remaining != '0) begin
            state_nxt = RD_HI;
            launch    = 1'b1;
          end else begin
            state_nxt = FIN;
          end
        end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy/done are registered from the next state so no input reaches them combinationally.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      addr_r     <= '0;
      remaining  <= '0;
      hi_r       <= '0;
      word_data  <= '0;
      word_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= (state_nxt == FIN);
      case (state)
        IDLE:
          if (start) begin
            addr_r    <= base_addr;
            remaining <= word_count;
          end
        RD_HI:
          if (sample_en) begin
            hi_r   <= sram_data;
            addr_r <= addr_r + 1'b1;
          end
        RD_LO:
          if (sample_en) begin
            word_data  <= {hi_r, sram_data};
            word_valid <= 1'b1;
            addr_r     <= addr_r + 1'b1;
            remaining  <= remaining - 1'b1;
          end
        PRESENT:
          if (word_valid && word_ready) word_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_weight_reader.sv
// Directed table-driven bench for sram_weight_reader with a behavioural SRAM model.
module tb_sram_weight_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [19:0] base_addr;
  logic [9:0]  word_count;
  logic        busy, done;
  logic [31:0] word_data;
  logic        word_valid;
  logic        word_ready;
  logic        CE_N, OE_N, WE_N, LB_N, UB_N;
  logic [19:0] sram_address;
  wire  [15:0] sram_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_weight_reader dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .base_addr    (base_addr),
    .word_count   (word_count),
    .busy         (busy),
    .done         (done),
    .word_data    (word_data),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .CE_N         (CE_N),
    .OE_N         (OE_N),
    .WE_N         (WE_N),
    .LB_N         (LB_N),
    .UB_N         (UB_N),
    .sram_address (sram_address),
    .sram_data    (sram_data)
  );

  function automatic logic [15:0] sram_model(input logic [19:0] a);
    if (a == 20'h00100) return 16'hDEAD;
    if (a == 20'h00101) return 16'hBEEF;
    return a[15:0] ^ 16'hA5A5;
  endfunction

  assign sram_data = (!CE_N && !OE_N) ? sram_model(sram_address) : 16'hzzzz;

  typedef struct {
    logic [19:0]      base;
    int               count;
    int               stall_idx;
    int               stall_len;
    int               spur_cyc;
    int               exp_busy;
    logic [2:0][31:0] w;
  } vec_t;

  function automatic vec_t mk(input logic [19:0] base, input int count, input int stall_idx,
                              input int stall_len, input int spur_cyc, input int exp_busy,
                              input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    vec_t v;
    v.base = base; v.count = count; v.stall_idx = stall_idx; v.stall_len = stall_len;
    v.spur_cyc = spur_cyc; v.exp_busy = exp_busy;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2;
    return v;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ctrl"}, longint'({CE_N, OE_N, WE_N, LB_N, UB_N}), 64'h1F);
    check({tag, "_addr"}, longint'(sram_address), 0);
    check({tag, "_data"}, longint'(word_data), 0);
    check({tag, "_valid"}, longint'(word_valid), 0);
    check({tag, "_busy"}, longint'(busy), 0);
    check({tag, "_done"}, longint'(done), 0);
  endtask

  task automatic run_row(input vec_t v, input string tag);
    logic [31:0] got[$];
    logic [19:0] addrs[$];
    logic [19:0] a_prev = '0;
    logic [31:0] held = '0;
    logic [19:0] exp_a;
    logic        ce_prev = 1'b1;
    bit          finished = 0, stall_ok = 1, we_ok = 1;
    int cyc = 0, idx = 0, stall_cnt = 0, first_valid = -1, last_hs = -1;
    int done_cyc = -1, busy_cnt = 0, ce_cnt = 0, done_cnt = 0;

    @(negedge clk);
    base_addr  = v.base;
    word_count = 10'(v.count);
    word_ready = 1'b1;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    base_addr  = 20'h5A5A5;
    word_count = 10'd7;

    while (!finished && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == v.spur_cyc) begin
        start = 1'b1; base_addr = 20'h00500; word_count = 10'd5;
      end else begin
        start = 1'b0;
      end
      if (WE_N !== 1'b1) we_ok = 0;
      if (busy) busy_cnt++;
      if (!CE_N) begin
        ce_cnt++;
        if (ce_prev || sram_address != a_prev) addrs.push_back(sram_address);
      end
      ce_prev = CE_N;
      a_prev  = sram_address;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (word_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (idx == v.stall_idx && stall_cnt < v.stall_len) begin
          if (stall_cnt == 0) held = word_data;
          else if (word_data !== held) stall_ok = 0;
          if (CE_N !== 1'b1 || OE_N !== 1'b1) stall_ok = 0;
          stall_cnt++;
          word_ready = 1'b0;
        end else begin
          got.push_back(word_data);
          idx++;
          last_hs    = cyc;
          word_ready = 1'b1;
        end
      end
      if (done_cyc >= 0 && cyc > done_cyc + 2) finished = 1;
    end
    start = 1'b0;

    check({tag, "_finished"}, longint'(finished), 1);
    check({tag, "_n_words"}, got.size(), v.count);
    for (int i = 0; i < v.count && i < got.size(); i++)
      check($sformatf("%s_word%0d", tag, i), longint'(got[i]), longint'(v.w[i]));
    check({tag, "_first_valid"}, first_valid, (v.count > 0) ? 7 : -1);
    check({tag, "_done_cyc"}, done_cyc, v.exp_busy);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_busy_cycles"}, busy_cnt, v.exp_busy);
    if (v.count > 0) check({tag, "_done_after_hs"}, done_cyc, last_hs + 1);
    check({tag, "_ce_cycles"}, ce_cnt, 6 * v.count);
    check({tag, "_n_addrs"}, addrs.size(), 2 * v.count);
    for (int i = 0; i < 2 * v.count && i < addrs.size(); i++) begin
      exp_a = v.base + 20'(i);
      check($sformatf("%s_addr%0d", tag, i), longint'(addrs[i]), longint'(exp_a));
    end
    if (v.stall_len > 0) check({tag, "_stall_stable"}, longint'(stall_ok), 1);
    check({tag, "_we_n_high"}, longint'(we_ok), 1);
  endtask

  vec_t vecs[5];

  initial begin
    bit quiet_ok;
    vecs[0] = mk(20'h00100, 1, 99, 0,  0, 8,  32'hDEADBEEF, 32'h0,        32'h0);
    vecs[1] = mk(20'h00200, 3, 1,  10, 0, 32, 32'hA7A5A7A4, 32'hA7A7A7A6, 32'hA7A1A7A0);
    vecs[2] = mk(20'hFFFFE, 2, 99, 0,  0, 15, 32'h5A5B5A5A, 32'hA5A5A5A4, 32'h0);
    vecs[3] = mk(20'h00000, 0, 99, 0,  0, 1,  32'h0,        32'h0,        32'h0);
    vecs[4] = mk(20'h00300, 1, 99, 0,  2, 8,  32'hA6A5A6A4, 32'h0,        32'h0);

    reset = 1'b0; start = 1'b0; word_ready = 1'b0;
    base_addr = '0; word_count = '0;
    repeat (3) @(negedge clk);
    check_reset_values("por");
    reset = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_row(vecs[i], $sformatf("row%0d", i));

    // Reset in the middle of the second word's low-half read.
    @(negedge clk);
    base_addr = 20'h00200; word_count = 10'd3; word_ready = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (11) @(negedge clk);
    check("mid_pre_addr", longint'(sram_address), 64'h203);
    check("mid_pre_oe", longint'(OE_N), 0);
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("mid");
    reset = 1'b1;
    quiet_ok = 1;
    repeat (8) begin
      @(negedge clk);
      if (done || busy || word_valid || !CE_N) quiet_ok = 0;
    end
    check("mid_quiet_after", longint'(quiet_ok), 1);
    run_row(mk(20'h00400, 1, 99, 0, 0, 8, 32'hA1A5A1A4, 32'h0, 32'h0), "post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sram_weight_reader.md
# sram_weight_reader

Read-back engine for the weight image stored in external 16-bit SRAM by the training controller. It is the reader counterpart of that writer. Each 32-bit word is stored as two consecutive 16-bit halves: high half at the even offset, low half at the next address. The block drives the SRAM pins directly in read-only mode, reassembles each pair of halves into a 32-bit word, and presents the words in order on a valid/ready stream to the inference datapath or the display logic.

## Interface
Parameters:
- ADDR_W, 20, SRAM address width.
- CNT_W, 10, width of word_count.
- WAIT_CYCLES, 2, extra cycles address/OE are held before sampling sram_data (≥0).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low; sampled on clk.
- start  in  1  one-cycle request; ignored unless idle.
- base_addr  in  ADDR_W  SRAM address of the first high half; latched on accepted start.
- word_count  in  CNT_W  number of 32-bit words to read; latched on accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the transfer completes.
- word_data  out  32  assembled word {hi, lo}.
- word_valid  out  1  word_data is valid; held until accepted.
- word_ready  in  1  consumer accepts when word_valid && word_ready.
- CE_N, OE_N, WE_N, LB_N, UB_N  out  1 each  SRAM controls, active-low.
- sram_address  out  ADDR_W  SRAM address.
- sram_data  inout  16  SRAM data; never driven by this block (always high-Z).

## Operation
- FSM states: IDLE, RD_HI, RD_LO, PRESENT, FIN.
- IDLE:
  - On start, latch base_addr into addr_r and word_count into remaining.
  - If word_count == 0, go to FIN. Otherwise go to RD_HI.
- RD_HI:
  - sram_address = addr_r; CE_N = OE_N = LB_N = UB_N = 0.
  - Hold for WAIT_CYCLES+1 cycles using phase counter ph.
  - On the final cycle, capture sram_data into hi_r, increment addr_r, and go to RD_LO.
- RD_LO:
  - Same access pattern as RD_HI.
  - On the final cycle, capture into word_data[15:0], load word_data[31:16] from hi_r, set word_valid, increment addr_r, decrement remaining, and go to PRESENT.
- PRESENT:
  - Controls are deasserted: CE_N = OE_N = LB_N = UB_N = 1.
  - word_valid and word_data stay stable until word_ready.
  - On handshake, clear word_valid. Go to RD_HI if remaining ≠ 0, else go to FIN.
- FIN: done = 1 for exactly one cycle, then IDLE.
- WE_N is constant 1. The block never writes to SRAM.
- Address arithmetic is modulo 2^ADDR_W, so addr_r wraps from all-ones to 0 silently.
- start while busy is ignored, with no side effects.
- word_ready while word_valid = 0 is ignored.

## Timing
- Reset values:
  - CE_N, OE_N, WE_N, LB_N, UB_N = 1.
  - sram_address = 0, word_data = 0, word_valid = 0, busy = 0, done = 0.
  - State = IDLE.
- Reset asserted mid-transfer: on the next edge, all reset values take effect, any in-flight half is discarded, and done does not pulse.
- All outputs are registered. No combinational path from word_ready to any output.
- start accepted at edge T: busy = 1 and RD_HI controls are asserted from T+1.
- Per-word latency: 2·(WAIT_CYCLES+1) read cycles, then word_valid rises. With WAIT_CYCLES = 2, word_valid rises 6 cycles after RD_HI is entered.
- Minimum throughput is one word per 2·(WAIT_CYCLES+1)+1 cycles when word_ready is held high.
- Sampling happens at the end of the last access cycle. sram_address and OE_N are stable for the whole access window.
- word_count == 0: done pulses at T+1 (FIN) and busy is high only that cycle. No SRAM access occurs.
- done pulses the cycle after the last handshake.

## Structure
- Package sram_rd_pkg holds:
  - The state enum (IDLE, RD_HI, RD_LO, PRESENT, FIN).
  - SRAM_ADDR_W = 20 and SRAM_DATA_W = 16, shared with the SRAM write path.
- One sub-module is natural: sram_read_phase. It drives CE_N/OE_N/LB_N/UB_N and sram_address for one half-word access, counts WAIT_CYCLES, and pulses sample_en on the final cycle. The top FSM instantiates it once and calls it twice per word.

## Test plan
- Single word, WAIT_CYCLES = 2. Setup: SRAM model with mem[0x100] = 0xDEAD, mem[0x101] = 0xBEEF; base_addr = 0x100, word_count = 1; word_ready held 1.
  - Required: word_data = 0xDEADBEEF, with word_valid first high 7 cycles after the start edge.
  - Required: done pulses 1 cycle after the handshake; addresses seen are 0x100, 0x101.
- Backpressure. Setup: word_count = 3; word_ready low for 10 cycles on the second word.
  - Required: word_data is stable and word_valid held throughout, with CE_N = OE_N = 1.
  - Required: the three words arrive in address order.
- Zero count: start with word_count = 0 → busy high for 1 cycle and done at T+1; CE_N never goes low.
- Wrap-around: base_addr = 0xFFFFE, word_count = 2 → sram_address sequence is 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
- Reset mid-read: reset low during RD_LO of word 2 → next cycle shows all reset values, with no done and no word_valid.
  - Required: a subsequent start runs cleanly from the new base_addr.
- start while busy: pulse start with a different base_addr during RD_HI → ignored; the original transfer completes unchanged.
- Across all scenarios: WE_N = 1 at all times and sram_data is never driven.
